// File: rtl/udma_ctrl_seq_pkg.sv
// ----------------------------------------------------------------------------
// udma_ctrl_seq_pkg
// Shared definitions for the uDMA global control block: the word addresses of
// the configuration registers and the state type of the peripheral reset
// sequencer.
// ----------------------------------------------------------------------------
package udma_ctrl_seq_pkg;

    localparam logic [4:0] ADDR_CG         = 5'd0;
    localparam logic [4:0] ADDR_CG_SET     = 5'd1;
    localparam logic [4:0] ADDR_CG_CLR     = 5'd2;
    localparam logic [4:0] ADDR_RST        = 5'd3;
    localparam logic [4:0] ADDR_RST_LEN    = 5'd4;
    localparam logic [4:0] ADDR_EXT_HS     = 5'd5;
    localparam logic [4:0] ADDR_CFG_EVT    = 5'd6;  // first of N_EVT_CMP/4 words
    localparam logic [4:0] ADDR_EVT_STATUS = 5'd10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PULSE,
        ST_GUARD
    } rst_seq_state_t;

endpackage

// File: rtl/udma_ctrl_rst_seq.sv
// ----------------------------------------------------------------------------
// udma_ctrl_rst_seq
// Timed peripheral reset sequencer. A launch request ORs its mask into the
// pending set; from IDLE the pending set becomes the active set, which is
// held in reset for max(rst_len_i,1) cycles (PULSE) and then kept clocked for
// GUARD_CYCLES more cycles (GUARD) before returning to IDLE.
// Ports:
//   clk_i, rstn_i   clock, synchronous active-low reset
//   launch_i        RST register write strobe
//   mask_i          peripheral mask of that write
//   rst_len_i       pulse length in cycles (0 treated as 1)
//   rst_value_o     active-high peripheral resets
//   force_o         peripherals whose clock must be forced on
//   mask_rd_o       active | pending, for register readback
//   busy_o          sequencer not idle or work pending
// ----------------------------------------------------------------------------
module udma_ctrl_rst_seq
    import udma_ctrl_seq_pkg::*;
#(
    parameter int N_PERIPHS    = 6,
    parameter int RST_CNT_W    = 8,
    parameter int GUARD_CYCLES = 2
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 launch_i,
    input  logic [N_PERIPHS-1:0] mask_i,
    input  logic [RST_CNT_W-1:0] rst_len_i,
    output logic [N_PERIPHS-1:0] rst_value_o,
    output logic [N_PERIPHS-1:0] force_o,
    output logic [N_PERIPHS-1:0] mask_rd_o,
    output logic                 busy_o
);

    localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
    localparam logic [RST_CNT_W-1:0] CNT_ONE   = RST_CNT_W'(1);
    localparam logic [GW-1:0]        GUARD_ONE = GW'(1);
    localparam logic [GW-1:0]        GUARD_LD  = GW'(GUARD_CYCLES - 1);

    rst_seq_state_t       state_q, state_d;
    logic [RST_CNT_W-1:0] cnt_q, cnt_d;
    logic [GW-1:0]        guard_q, guard_d;
    logic [N_PERIPHS-1:0] active_q, active_d;
    logic [N_PERIPHS-1:0] pending_q, pending_d;
    logic [N_PERIPHS-1:0] pending_keep;

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            guard_q   <= '0;
            active_q  <= '0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            guard_q   <= guard_d;
            active_q  <= active_d;
            pending_q <= pending_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        guard_d      = guard_q;
        active_d     = active_q;
        pending_keep = pending_q;
        unique case (state_q)
            ST_IDLE: begin
                if (|pending_q) begin
                    active_d     = pending_q;
                    pending_keep = '0;
                    cnt_d        = (rst_len_i == '0) ? '0 : rst_len_i - CNT_ONE;
                    state_d      = ST_PULSE;
                end
            end
            ST_PULSE: begin
                if (cnt_q == '0) begin
                    guard_d = GUARD_LD;
                    state_d = ST_GUARD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_GUARD: begin
                if (guard_q == '0) begin
                    active_d = '0;
                    state_d  = ST_IDLE;
                end else begin
                    guard_d = guard_q - GUARD_ONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Bits in the (next) active set are not queued again.
        pending_d = pending_keep | (launch_i ? (mask_i & ~active_d) : '0);
    end

    assign rst_value_o = (state_q == ST_PULSE) ? active_q : '0;
    assign force_o     = (state_q != ST_IDLE)  ? active_q : '0;
    assign mask_rd_o   = active_q | pending_q;
    assign busy_o      = (state_q != ST_IDLE) || (|pending_q);

endmodule

// File: rtl/udma_ctrl_seq.sv
// ----------------------------------------------------------------------------
// udma_ctrl_seq
// uDMA global control: clock-gate register (full write or set/clear mask),
// timed peripheral reset pulses, external handshake enable and a bank of
// event-ID comparators with registered match pulses and sticky status.
// Ports:
//   clk_i, rstn_i          clock, synchronous active-low reset
//   cfg_*                  APB-style config access (reads combinational)
//   rst_value_o            per-peripheral reset, active-high
//   cg_value_o, cg_core_o  peripheral / core clock enables
//   ext_hs_en_o            external handshake enable
//   rst_busy_o             reset sequencer busy
//   event_*                event strobe/ID in, registered match pulses out
// ----------------------------------------------------------------------------
module udma_ctrl_seq
    import udma_ctrl_seq_pkg::*;
#(
    parameter int N_PERIPHS    = 6,
    parameter int N_EVT_CMP    = 4,
    parameter int EVT_W        = 8,
    parameter int RST_CNT_W    = 8,
    parameter int RST_LEN_DEF  = 16,
    parameter int GUARD_CYCLES = 2
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic [31:0]          cfg_data_i,
    input  logic [4:0]           cfg_addr_i,
    input  logic                 cfg_valid_i,
    input  logic                 cfg_rwn_i,
    output logic [31:0]          cfg_data_o,
    output logic                 cfg_ready_o,
    output logic [N_PERIPHS-1:0] rst_value_o,
    output logic [N_PERIPHS-1:0] cg_value_o,
    output logic                 cg_core_o,
    output logic                 ext_hs_en_o,
    output logic                 rst_busy_o,
    input  logic                 event_valid_i,
    input  logic [EVT_W-1:0]     event_data_i,
    output logic                 event_ready_o,
    output logic [N_EVT_CMP-1:0] event_o
);

    localparam int N_EVT_WORDS = N_EVT_CMP / 4;

    logic [N_PERIPHS-1:0]            r_cg_q, r_cg_d;
    logic                            r_cg_core_q, r_cg_core_d;
    logic [RST_CNT_W-1:0]            rst_len_q, rst_len_d;
    logic                            ext_hs_q, ext_hs_d;
    logic [N_EVT_CMP-1:0][EVT_W-1:0] cmp_q, cmp_d;
    logic [N_EVT_CMP-1:0]            status_q, status_d;
    logic [N_EVT_CMP-1:0]            event_q;
    logic [N_EVT_CMP-1:0]            hits;

    logic                 wr;
    logic                 rst_launch;
    logic [N_PERIPHS-1:0] force_mask;
    logic [N_PERIPHS-1:0] rst_mask_rd;

    assign wr         = cfg_valid_i && !cfg_rwn_i;
    assign rst_launch = wr && (cfg_addr_i == ADDR_RST);

    udma_ctrl_rst_seq #(
        .N_PERIPHS    (N_PERIPHS),
        .RST_CNT_W    (RST_CNT_W),
        .GUARD_CYCLES (GUARD_CYCLES)
    ) u_rst_seq (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .launch_i    (rst_launch),
        .mask_i      (cfg_data_i[N_PERIPHS-1:0]),
        .rst_len_i   (rst_len_q),
        .rst_value_o (rst_value_o),
        .force_o     (force_mask),
        .mask_rd_o   (rst_mask_rd),
        .busy_o      (rst_busy_o)
    );

    always_comb begin
        for (int i = 0; i < N_EVT_CMP; i++) begin
            hits[i] = event_valid_i && (event_data_i == cmp_q[i]);
        end
    end

    always_comb begin
        r_cg_d      = r_cg_q;
        r_cg_core_d = r_cg_core_q;
        rst_len_d   = rst_len_q;
        ext_hs_d    = ext_hs_q;
        cmp_d       = cmp_q;
        status_d    = status_q;
        if (wr) begin
            case (cfg_addr_i)
                ADDR_CG: begin
                    r_cg_d      = cfg_data_i[N_PERIPHS-1:0];
                    r_cg_core_d = cfg_data_i[31];
                end
                ADDR_CG_SET:     r_cg_d    = r_cg_q | cfg_data_i[N_PERIPHS-1:0];
                ADDR_CG_CLR:     r_cg_d    = r_cg_q & ~cfg_data_i[N_PERIPHS-1:0];
                ADDR_RST_LEN:    rst_len_d = cfg_data_i[RST_CNT_W-1:0];
                ADDR_EXT_HS:     ext_hs_d  = cfg_data_i[0];
                ADDR_EVT_STATUS: status_d  = status_q & ~cfg_data_i[N_EVT_CMP-1:0];
                default: begin
                    for (int w = 0; w < N_EVT_WORDS; w++) begin
                        if (cfg_addr_i == ADDR_CFG_EVT + 5'(w)) begin
                            for (int j = 0; j < 4; j++) begin
                                cmp_d[4*w+j] = cfg_data_i[8*j +: EVT_W];
                            end
                        end
                    end
                end
            endcase
        end
        // Applied after any W1C so a same-cycle hit keeps its bit set.
        status_d = status_d | hits;
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_cg_q      <= '0;
            r_cg_core_q <= 1'b0;
            rst_len_q   <= RST_CNT_W'(RST_LEN_DEF);
            ext_hs_q    <= 1'b0;
            cmp_q       <= '0;
            status_q    <= '0;
            event_q     <= '0;
        end else begin
            r_cg_q      <= r_cg_d;
            r_cg_core_q <= r_cg_core_d;
            rst_len_q   <= rst_len_d;
            ext_hs_q    <= ext_hs_d;
            cmp_q       <= cmp_d;
            status_q    <= status_d;
            event_q     <= hits;
        end
    end

    always_comb begin
        cfg_data_o = '0;
        case (cfg_addr_i)
            ADDR_CG: begin
                cfg_data_o[N_PERIPHS-1:0] = r_cg_q;
                cfg_data_o[31]            = r_cg_core_q;
            end
            ADDR_RST:        cfg_data_o[N_PERIPHS-1:0] = rst_mask_rd;
            ADDR_RST_LEN:    cfg_data_o[RST_CNT_W-1:0] = rst_len_q;
            ADDR_EXT_HS:     cfg_data_o[0]             = ext_hs_q;
            ADDR_EVT_STATUS: cfg_data_o[N_EVT_CMP-1:0] = status_q;
            default: begin
                for (int w = 0; w < N_EVT_WORDS; w++) begin
                    if (cfg_addr_i == ADDR_CFG_EVT + 5'(w)) begin
                        for (int j = 0; j < 4; j++) begin
                            cfg_data_o[8*j +: EVT_W] = cmp_q[4*w+j];
                        end
                    end
                end
            end
        endcase
    end

    assign cg_value_o    = r_cg_q | force_mask;
    assign cg_core_o     = (|cg_value_o) | r_cg_core_q;
    assign ext_hs_en_o   = ext_hs_q;
    assign event_o       = event_q;
    assign cfg_ready_o   = 1'b1;
    assign event_ready_o = 1'b1;

endmodule

// File: doc/udma_ctrl_seq.md
Name: udma_ctrl_seq

Overview:
- Next-generation uDMA global control block: per-peripheral clock-gate and reset control, an external-handshake enable, and event-matching comparators.
- Generalised over the previous controller: the number of event comparators is a parameter, and clock-gate writes can be full-register or set/clear-mask.
- Peripheral resets are timed, self-clearing pulses with the clock forced on during the pulse, plus a post-reset guard period.
- Event hits are registered and recorded in sticky status bits.
- Sits between the APB config bus and the uDMA core / peripheral channels.

Parameters:
- N_PERIPHS, 6: number of peripheral channels (1..31).
- N_EVT_CMP, 4: number of event comparators (multiple of 4, 4..16).
- EVT_W, 8: event ID width.
- RST_CNT_W, 8: width of the reset-length counter.
- RST_LEN_DEF, 16: reset value of RST_LEN.
- GUARD_CYCLES, 2: cycles the clock stays forced on after reset release (≥1).

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  reset; synchronous, active-low, sampled on rising clk_i
- cfg_data_i  in  32  write data
- cfg_addr_i  in  5  word address
- cfg_valid_i  in  1  access strobe
- cfg_rwn_i  in  1  1=read, 0=write
- cfg_data_o  out  32  read data, combinational
- cfg_ready_o  out  1  constant 1
- rst_value_o  out  N_PERIPHS  per-peripheral reset, active-high
- cg_value_o  out  N_PERIPHS  per-peripheral clock enable
- cg_core_o  out  1  uDMA core clock enable
- ext_hs_en_o  out  1  external handshake enable
- rst_busy_o  out  1  reset sequencer not idle
- event_valid_i  in  1  event strobe
- event_data_i  in  EVT_W  event ID
- event_ready_o  out  1  constant 1
- event_o  out  N_EVT_CMP  registered match pulses

Behaviour:
- Reset: synchronous active-low on rstn_i. All registers, outputs, counters and status are 0, except RST_LEN = RST_LEN_DEF. FSM resets to ST_IDLE.
- Register map (word address, decimal):
  - 0 CG: [N_PERIPHS-1:0] r_cg, [31] r_cg_core; RW.
  - 1 CG_SET: write 1 sets r_cg bits; reads 0.
  - 2 CG_CLR: write 1 clears r_cg bits; reads 0.
  - 3 RST: write launches a reset pulse for the mask in [N_PERIPHS-1:0]; reads the active|pending mask.
  - 4 RST_LEN: [RST_CNT_W-1:0]; RW.
  - 5 EXT_HS_CTRL: [0]; RW.
  - 6..6+N_EVT_CMP/4-1 CFG_EVT: 4 comparator IDs per word, each in the low EVT_W bits of a byte lane; RW.
  - 10 EVT_STATUS: sticky hits; write 1 to clear.
  - Unmapped addresses read 0; writes to them are ignored.
- Write/read timing: writes take effect on the clock edge where cfg_valid_i=1 and cfg_rwn_i=0. Reads are same-cycle combinational.
- Clock-enable outputs:
  - cg_value_o = r_cg | force_mask (force_mask = active mask in ST_PULSE/ST_GUARD).
  - cg_core_o = |cg_value_o | r_cg_core.
- Events:
  - event_o[i] registers event_valid_i & (event_data_i == cmp[i]); 1-cycle latency.
  - A hit sets status[i]. If a hit and a W1C land on the same bit in the same cycle, set wins.
- Reset sequencer states:
  - ST_IDLE: if pending≠0, load active=pending, clear pending, load cnt=max(RST_LEN,1)-1, go to ST_PULSE. A RST write with nonzero mask in IDLE enters PULSE on the next edge (1-cycle launch latency).
  - ST_PULSE: rst_value_o=active. Decrement cnt; at cnt==0 load guard=GUARD_CYCLES-1 and go to ST_GUARD. Pulse width is exactly max(RST_LEN,1) cycles.
  - ST_GUARD: rst_value_o=0, clock still forced on for active. At guard==0 clear active and go to ST_IDLE.
- rst_busy_o = state≠ST_IDLE or pending≠0.
- Boundary cases:
  - RST write while busy: mask ORs into pending and launches after return to IDLE. Bits already active are not retriggered.
  - A RST write of mask 0 is ignored.
  - RST_LEN writes during a pulse affect only the next launch.
  - RST_LEN=0 behaves as 1.
  - A reset asserted mid-sequence aborts immediately: all outputs 0, FSM to ST_IDLE.

Decomposition:
- Package udma_ctrl_seq_pkg holds:
  - register address localparams;
  - the rst_seq_state_t enum {ST_IDLE, ST_PULSE, ST_GUARD}.
- Sub-module udma_ctrl_rst_seq holds the FSM, counters, active/pending masks, and the rst/force/busy outputs. Top level holds the register file and comparators.

Test Plan:
- Reset then read all addresses → RST_LEN=16, everything else 0. Outputs 0, except constants cfg_ready_o=1 and event_ready_o=1.
- Write CG=0x0000_0005, then CG_SET=0x2, then CG_CLR=0x1 → cg_value_o 0x05→0x07→0x06, with cg_core_o=1 throughout. Write CG=0 → cg_core_o=0.
- RST_LEN=3, RST=0x4 with r_cg=0:
  - rst_value_o=0x04 for exactly 3 cycles starting 1 cycle after the write;
  - cg_value_o[2]=1 for 3+2 cycles;
  - rst_busy_o drops the cycle after the guard ends.
- Write RST=0x1 during an active 0x4 pulse → 0x4 pulse completes unchanged. 0x1 pulse starts 1 cycle after the guard ends. RST reads 0x5 meanwhile.
- CFG_EVT word 6=0x0403_0201, event 0x03 valid → event_o=0x4 one cycle later and EVT_STATUS=0x4. Same-cycle W1C 0x4 plus another 0x03 hit → status stays 0x4.
- Assert rstn_i low for 1 cycle mid-PULSE → next cycle rst_value_o=0, rst_busy_o=0, RST_LEN=16.
